// File: rtl/gpa_fhdo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpa_fhdo_pkg
//  Description : Shared constants for the GPA-FHDO DAC SPI responder: frame
//                geometry, field positions, register addresses, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package gpa_fhdo_pkg;

   // Frame geometry and field positions (MSB first on the wire)
   localparam int FRAME_BITS     = 24;
   localparam int FRAME_RW_BIT   = 23;
   localparam int FRAME_ADDR_MSB = 19;
   localparam int FRAME_ADDR_LSB = 16;
   localparam int FRAME_DATA_MSB = 15;
   localparam int FRAME_DATA_LSB = 0;

   // Bit counter: a complete frame, and the saturation value that keeps
   // over-long frames from wrapping back onto a valid count
   localparam logic [4:0] CNT_FRAME = 5'd24;
   localparam logic [4:0] CNT_SAT   = 5'd25;

   // Register map
   localparam logic [3:0] ADDR_SYNC    = 4'h2;
   localparam logic [3:0] ADDR_BRDCAST = 4'h6;
   localparam logic [3:0] ADDR_DAC0    = 4'h8;
   localparam logic [3:0] ADDR_DAC1    = 4'h9;
   localparam logic [3:0] ADDR_DAC2    = 4'hA;
   localparam logic [3:0] ADDR_DAC3    = 4'hB;

   // Frame FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gpa_fhdo_spi_slave_spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Multi-stage synchronizer for one SPI pin with a history flop
//                providing rise/fall pulses in the clk domain. Resets to 0 so
//                a pin that is already low at reset release shows no edge.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_hist;

   // Synchronizer chain plus one history stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_pin};
         r_hist <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_sync[STAGES-1] & ~r_hist;
   assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule
`default_nettype wire

// File: rtl/gpa_fhdo_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : gpa_fhdo_spi_slave
//  Description : Oversampling SPI responder emulating the GPA-FHDO 4-channel
//                DAC: deserializes 24-bit frames and decodes register writes.
//                Optional readback on spi_sdo_o is enabled by defining the
//                macro GPA_FHDO_SPI_SLAVE_READBACK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module gpa_fhdo_spi_slave
   import gpa_fhdo_pkg::*;
#(
   parameter int          SYNC_STAGES  = 2,
   parameter logic [15:0] DAC_RST_VAL  = 16'h0000,
   parameter logic [15:0] SYNC_RST_VAL = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_clk_i,
   input  logic        spi_sdi_i,
   input  logic        spi_csn_i,
   output logic        spi_sdo_o,
   output logic [15:0] dac0_o,
   output logic [15:0] dac1_o,
   output logic [15:0] dac2_o,
   output logic [15:0] dac3_o,
   output logic [15:0] sync_reg_o,
   output logic [23:0] frame_o,
   output logic        frame_valid_o,
   output logic        frame_err_o
);

   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_sdi_level,  w_sdi_rise,  w_sdi_fall;
   logic w_csn_level,  w_csn_rise,  w_csn_fall;
   logic w_unused_edges;

   state_t r_state, w_state_nxt;
   logic   w_start, w_shift_fall, w_shift_rise, w_accept, w_reject;

   logic                  r_armed;
   logic [4:0]            r_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic [FRAME_BITS-1:0] r_frame;
   logic                  r_frame_valid, r_frame_err;
   logic [15:0]           r_dac0, r_dac1, r_dac2, r_dac3, r_sync;
   logic [3:0]            w_addr;
   logic [15:0]           w_data;

   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .i_pin(spi_clk_i),
      .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk(clk), .rst_n(rst_n), .i_pin(spi_sdi_i),
      .o_level(w_sdi_level), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_csn (
      .clk(clk), .rst_n(rst_n), .i_pin(spi_csn_i),
      .o_level(w_csn_level), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
   );

   // Edge/level outputs the frame logic has no use for
   assign w_unused_edges = w_sclk_level ^ w_sdi_rise ^ w_sdi_fall ^ w_sclk_rise ^ w_shift_rise;

   assign w_addr = r_shift[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
   assign w_data = r_shift[FRAME_DATA_MSB:FRAME_DATA_LSB];

   // Frame FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and per-cycle strobes; a CSN rise masks any same-cycle SCLK edge
   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_shift_fall = 1'b0;
      w_shift_rise = 1'b0;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_csn_fall && r_armed) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_csn_rise) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_shift_fall = w_sclk_fall;
               w_shift_rise = w_sclk_rise;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            if (r_cnt == CNT_FRAME) w_accept = 1'b1;
            else                    w_reject = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Arming, bit counter and deserializer; armed only after CSN seen idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         if (w_csn_level) r_armed <= 1'b1;
         if (w_start) begin
            r_cnt <= '0;
         end else if (w_shift_fall) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi_level};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   // Frame acceptance, status pulses and register-file write decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame       <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_dac0        <= DAC_RST_VAL;
         r_dac1        <= DAC_RST_VAL;
         r_dac2        <= DAC_RST_VAL;
         r_dac3        <= DAC_RST_VAL;
         r_sync        <= SYNC_RST_VAL;
      end else begin
         r_frame_valid <= w_accept;
         r_frame_err   <= w_reject;
         if (w_accept) begin
            r_frame <= r_shift;
            // Read frames never write; unmapped addresses are silent no-ops
            if (!r_shift[FRAME_RW_BIT]) begin
               case (w_addr)
                  ADDR_SYNC: r_sync <= w_data;
                  ADDR_BRDCAST: begin
                     r_dac0 <= w_data;
                     r_dac1 <= w_data;
                     r_dac2 <= w_data;
                     r_dac3 <= w_data;
                  end
                  ADDR_DAC0: r_dac0 <= w_data;
                  ADDR_DAC1: r_dac1 <= w_data;
                  ADDR_DAC2: r_dac2 <= w_data;
                  ADDR_DAC3: r_dac3 <= w_data;
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef GPA_FHDO_SPI_SLAVE_READBACK_EN
   logic [FRAME_BITS-1:0] r_rb_word, r_rb_shift;
   logic                  r_sdo;
   logic [15:0]           w_rd_val;

   // Register value returned by a read; BRDCAST and unmapped read as 0
   always_comb begin
      w_rd_val = 16'h0000;
      case (w_addr)
         ADDR_SYNC: w_rd_val = r_sync;
         ADDR_DAC0: w_rd_val = r_dac0;
         ADDR_DAC1: w_rd_val = r_dac1;
         ADDR_DAC2: w_rd_val = r_dac2;
         ADDR_DAC3: w_rd_val = r_dac3;
         default:   w_rd_val = 16'h0000;
      endcase
   end

   // Readback serializer: MSB on CSN fall, next bit on each SCLK rise,
   // word replaced (or cleared) at the end of every frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rb_word  <= '0;
         r_rb_shift <= '0;
         r_sdo      <= 1'b0;
      end else begin
         if (w_start) begin
            r_sdo      <= r_rb_word[FRAME_BITS-1];
            r_rb_shift <= {r_rb_word[FRAME_BITS-2:0], 1'b0};
         end else if (w_shift_rise) begin
            r_sdo      <= r_rb_shift[FRAME_BITS-1];
            r_rb_shift <= {r_rb_shift[FRAME_BITS-2:0], 1'b0};
         end
         if (r_state == ST_DONE) begin
            r_sdo      <= 1'b0;
            r_rb_shift <= '0;
            if (w_accept && r_shift[FRAME_RW_BIT]) r_rb_word <= {8'h00, w_rd_val};
            else                                   r_rb_word <= '0;
         end
      end
   end

   assign spi_sdo_o = r_sdo;
`else
   assign spi_sdo_o = 1'b0;
`endif

   assign dac0_o        = r_dac0;
   assign dac1_o        = r_dac1;
   assign dac2_o        = r_dac2;
   assign dac3_o        = r_dac3;
   assign sync_reg_o    = r_sync;
   assign frame_o       = r_frame;
   assign frame_valid_o = r_frame_valid;
   assign frame_err_o   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_gpa_fhdo_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpa_fhdo_spi_slave
//  Description : Self-checking bench for gpa_fhdo_spi_slave: directed vector
//                table, corner sequences and random frames against a frame-
//                level register-map model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpa_fhdo_spi_slave;

   localparam int SS = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_clk = 1'b1;
   logic        spi_sdi = 1'b0;
   logic        spi_csn = 1'b1;
   logic        spi_sdo;
   logic [15:0] dac0, dac1, dac2, dac3, sync_reg;
   logic [23:0] frame;
   logic        frame_valid, frame_err;

   gpa_fhdo_spi_slave #(.SYNC_STAGES(SS), .DAC_RST_VAL(16'h0000), .SYNC_RST_VAL(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_clk_i(spi_clk), .spi_sdi_i(spi_sdi), .spi_csn_i(spi_csn), .spi_sdo_o(spi_sdo),
      .dac0_o(dac0), .dac1_o(dac1), .dac2_o(dac2), .dac3_o(dac3),
      .sync_reg_o(sync_reg), .frame_o(frame),
      .frame_valid_o(frame_valid), .frame_err_o(frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_vpulse = 0;
   int n_epulse = 0;

   // Pulse counters, sampled on the inactive edge
   always @(negedge clk) begin
      if (frame_valid) n_vpulse++;
      if (frame_err)   n_epulse++;
   end

   // Reference model: register map state and pending readback word
   logic [15:0] m_dac [4];
   logic [15:0] m_sync;
   logic [23:0] m_frame;
   logic [23:0] m_rb;

   // Results of the most recent send_frame
   int          g_v, g_e, g_lat;
   logic [23:0] g_cap;

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      logic [15:0] e_dac0, e_dac1, e_dac2, e_dac3, e_sync;
      int          e_v, e_e;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input logic [31:0] b, input int n,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic [15:0] d3,
                               input logic [15:0] s, input int v, input int e);
      vec_t r;
      r.bits = b; r.nbits = n;
      r.e_dac0 = d0; r.e_dac1 = d1; r.e_dac2 = d2; r.e_dac3 = d3; r.e_sync = s;
      r.e_v = v; r.e_e = e;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [15:0] rd_val(input logic [3:0] a);
      case (a)
         4'h2:    return m_sync;
         4'h8:    return m_dac[0];
         4'h9:    return m_dac[1];
         4'hA:    return m_dac[2];
         4'hB:    return m_dac[3];
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dac[i] = 16'h0000;
      m_sync = 16'h0000; m_frame = 24'h0; m_rb = 24'h0;
   endtask

   // Frame-level rules: 24 bits accepted, anything else discarded
   task automatic model_frame(input logic [23:0] f, input int nb);
      logic [3:0]  a;
      logic [15:0] d;
      logic [23:0] nrb;
      a = f[19:16]; d = f[15:0]; nrb = 24'h0;
      if (nb == 24) begin
         m_frame = f;
`ifdef GPA_FHDO_SPI_SLAVE_READBACK_EN
         if (f[23]) nrb = {8'h00, rd_val(a)};
`endif
         if (!f[23]) begin
            if (a == 4'h2) m_sync = d;
            else if (a == 4'h6) for (int i = 0; i < 4; i++) m_dac[i] = d;
            else if (a >= 4'h8 && a <= 4'hB) m_dac[a - 4'h8] = d;
         end
      end
      m_rb = nrb;
   endtask

   // Shift nbits out MSB first at SCLK = clk/8, capturing sdo before each fall
   task automatic shift_bits(input logic [31:0] bits, input int nbits, output logic [23:0] cap);
      cap = 24'h0;
      for (int i = 0; i < nbits; i++) begin
         spi_sdi = bits[nbits-1-i];
         wait_clk(2);
         if (i < 24) cap[23-i] = spi_sdo;
         spi_clk = 1'b0;
         wait_clk(4);
         spi_clk = 1'b1;
         wait_clk(2);
      end
   endtask

   task automatic send_frame(input logic [31:0] bits, input int nbits);
      int v0, e0;
      bit done;
      v0 = n_vpulse; e0 = n_epulse;
      spi_csn = 1'b0;
      wait_clk(4);
      shift_bits(bits, nbits, g_cap);
      spi_csn = 1'b1;
      g_lat = 0; done = 0;
      for (int k = 1; k <= 30 && !done; k++) begin
         @(posedge clk); #1;
         if (frame_valid || frame_err) begin g_lat = k; done = 1; end
      end
      wait_clk(12);
      g_v = n_vpulse - v0;
      g_e = n_epulse - e0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".dac0"}, 32'(dac0), 32'(m_dac[0]));
      chk({tag, ".dac1"}, 32'(dac1), 32'(m_dac[1]));
      chk({tag, ".dac2"}, 32'(dac2), 32'(m_dac[2]));
      chk({tag, ".dac3"}, 32'(dac3), 32'(m_dac[3]));
      chk({tag, ".sync"}, 32'(sync_reg), 32'(m_sync));
      chk({tag, ".frame"}, 32'(frame), 32'(m_frame));
   endtask

   // Send one frame, advance the model and compare everything observable
   task automatic run_frame(input string tag, input logic [31:0] bits, input int nb);
      logic [23:0] exp_sdo;
      exp_sdo = m_rb;
      send_frame(bits, nb);
      model_frame(bits[23:0], nb);
      chk({tag, ".valid"}, 32'(g_v), (nb == 24) ? 32'd1 : 32'd0);
      chk({tag, ".err"},   32'(g_e), (nb == 24) ? 32'd0 : 32'd1);
      chk({tag, ".lat"},   32'(g_lat), 32'(SS + 2));
      if (nb >= 24) chk({tag, ".sdo"}, 32'(g_cap), 32'(exp_sdo));
      check_regs(tag);
   endtask

   initial begin
      logic [23:0] dummy;
      logic [23:0] f;
      logic [31:0] bits;
      logic [3:0]  addrs [8];
      int          v0, e0, nb;

      vecs[0] = mk(32'h0009ABCD, 24, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1, 0);
      vecs[1] = mk(32'h00061234, 24, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 1, 0);
      vecs[2] = mk(32'h0008FFFF >> 1, 23, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 0, 1);
      vecs[3] = mk({7'h0, 24'h08FFFF, 1'b1}, 25, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 0, 1);
      vecs[4] = mk(32'h00020005, 24, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0005, 1, 0);
      vecs[5] = mk(32'h000B7777, 24, 16'h1234, 16'h1234, 16'h1234, 16'h7777, 16'h0005, 1, 0);
      vecs[6] = mk(32'h008B0000, 24, 16'h1234, 16'h1234, 16'h1234, 16'h7777, 16'h0005, 1, 0);
      vecs[7] = mk(32'h00000000, 24, 16'h1234, 16'h1234, 16'h1234, 16'h7777, 16'h0005, 1, 0);
      vecs[8] = mk(32'h000F1111, 24, 16'h1234, 16'h1234, 16'h1234, 16'h7777, 16'h0005, 1, 0);
      addrs = '{4'h0, 4'h2, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};

      // Reset state
      model_reset();
      wait_clk(4);
      chk("rst.sdo",   32'(spi_sdo), 32'd0);
      chk("rst.valid", 32'(frame_valid), 32'd0);
      chk("rst.err",   32'(frame_err), 32'd0);
      check_regs("rst");
      rst_n = 1'b1;
      wait_clk(10);

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         logic [23:0] exp_sdo;
         exp_sdo = m_rb;
         send_frame(vecs[i].bits, vecs[i].nbits);
         model_frame(vecs[i].bits[23:0], vecs[i].nbits);
         chk($sformatf("vec%0d.valid", i), 32'(g_v), 32'(vecs[i].e_v));
         chk($sformatf("vec%0d.err", i),   32'(g_e), 32'(vecs[i].e_e));
         chk($sformatf("vec%0d.lat", i),   32'(g_lat), 32'(SS + 2));
         chk($sformatf("vec%0d.dac0", i),  32'(dac0), 32'(vecs[i].e_dac0));
         chk($sformatf("vec%0d.dac1", i),  32'(dac1), 32'(vecs[i].e_dac1));
         chk($sformatf("vec%0d.dac2", i),  32'(dac2), 32'(vecs[i].e_dac2));
         chk($sformatf("vec%0d.dac3", i),  32'(dac3), 32'(vecs[i].e_dac3));
         chk($sformatf("vec%0d.sync", i),  32'(sync_reg), 32'(vecs[i].e_sync));
         chk($sformatf("vec%0d.frame", i), 32'(frame), 32'(m_frame));
         if (vecs[i].nbits >= 24) chk($sformatf("vec%0d.sdo", i), 32'(g_cap), 32'(exp_sdo));
      end
`ifdef GPA_FHDO_SPI_SLAVE_READBACK_EN
      // Write 0B7777 then read 8B0000: the dummy frame (vec7) carried the word
      send_frame(32'h008B0000, 24);
      model_frame(24'h8B0000, 24);
      run_frame("rb.dummy", 32'h00000000, 24);
      chk("rb.word", 32'(g_cap), 32'h00007777);
      chk("rb.dac3", 32'(dac3), 32'h00007777);
`endif

      // Reset after 10 bits with CSN still low: remainder must be ignored
      f = 24'h0BDEAD;
      spi_csn = 1'b0;
      wait_clk(4);
      shift_bits(32'(f) >> 14, 10, dummy);
      rst_n = 1'b0;
      #1;
      chk("midrst.async_dac3", 32'(dac3), 32'd0);
      model_reset();
      wait_clk(2);
      rst_n = 1'b1;
      v0 = n_vpulse; e0 = n_epulse;
      shift_bits(32'(f) & 32'h3FFF, 14, dummy);
      spi_csn = 1'b1;
      wait_clk(20);
      chk("midrst.valid", 32'(n_vpulse - v0), 32'd0);
      chk("midrst.err",   32'(n_epulse - e0), 32'd0);
      check_regs("midrst");
      run_frame("midrst.next", 32'h000A0042, 24);
      chk("midrst.dac2", 32'(dac2), 32'h00000042);

      // SCLK toggling with CSN high is ignored
      v0 = n_vpulse; e0 = n_epulse;
      for (int i = 0; i < 10; i++) begin
         spi_sdi = 1'($urandom);
         spi_clk = 1'b0; wait_clk(4);
         spi_clk = 1'b1; wait_clk(4);
      end
      chk("idle_sclk.valid", 32'(n_vpulse - v0), 32'd0);
      chk("idle_sclk.err",   32'(n_epulse - e0), 32'd0);
      run_frame("idle_sclk.next", 32'h00020005, 24);
      chk("idle_sclk.sync", 32'(sync_reg), 32'h00000005);

      // CSN rise and SCLK fall in the same cycle: CSN wins, frame stays 24 bits
      v0 = n_vpulse; e0 = n_epulse;
      spi_csn = 1'b0;
      wait_clk(4);
      shift_bits(32'h00090055, 24, dummy);
      spi_sdi = 1'b1;
      wait_clk(2);
      spi_clk = 1'b0;
      spi_csn = 1'b1;
      wait_clk(4);
      spi_clk = 1'b1;
      wait_clk(12);
      model_frame(24'h090055, 24);
      chk("csn_wins.valid", 32'(n_vpulse - v0), 32'd1);
      chk("csn_wins.err",   32'(n_epulse - e0), 32'd0);
      check_regs("csn_wins");

      // Random frames against the model
      for (int i = 0; i < 30; i++) begin
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(22, 26)) : 24;
         f[23]    = ($urandom_range(0, 3) == 0);
         f[22:20] = 3'($urandom);
         f[19:16] = addrs[$urandom_range(0, 7)];
         f[15:0]  = 16'($urandom);
         bits = (nb == 24) ? 32'(f) : $urandom;
         run_frame($sformatf("rnd%0d", i), bits, nb);
      end

      $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
